// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store access unit.
// Size encodings, FSM states, byte-lane and alignment functions.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  function automatic logic [3:0] byte_en(size_t size, logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    unique case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(size_t size, logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] lane_data(size_t size, logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    unique case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: shift the addressed lane down,
// then sign- or zero-extend to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;
  logic        sx8;
  logic        sx16;

  assign sh   = rdata_i >> {addr_lo_i, 3'b000};
  assign sx8  = ~uns_i & sh[7];
  assign sx16 = ~uns_i & sh[15];

  // Pick the extension for the access size.
  always_comb begin
    data_o = rdata_i;
    unique case (size_t'(size_i))
      SZ_BYTE: data_o = {{24{sx8}}, sh[7:0]};
      SZ_HALF: data_o = {{16{sx16}}, sh[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: one request at a time, alignment check,
// word-aligned memory access with wait states, extended load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  size_t              size_q, size_d;
  logic               uns_q, uns_d;
  logic [1:0]         alo_q, alo_d;
  logic               mem_en_q, mem_en_d;
  logic [3:0]         mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic [31:0]        ld_data;
  size_t              req_sz;

  assign req_sz = size_t'(req_size);

  load_align u_align (
    .rdata_i   (mem_rdata),
    .size_i    (size_q),
    .addr_lo_i (alo_q),
    .uns_i     (uns_q),
    .data_o    (ld_data)
  );

  // Next-state, memory strobes and response decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    alo_d       = alo_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_sz;
          uns_d   = req_unsigned;
          alo_d   = req_addr[1:0];
          if (misaligned(req_sz, req_addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ACCESS;
            cnt_d       = CNT_W'(WAIT_STATES);
            mem_en_d    = 1'b1;
            mem_we_d    = req_write ?
                          byte_en(req_sz, req_addr[1:0]) : 4'b0000;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = lane_data(req_sz, req_wdata);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 32'd0 : ld_data;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_en_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      alo_q       <= 2'b00;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      alo_q       <= alo_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
// Three instances: WAIT_STATES = 0, 1, 3 (index 0, 1, 2).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid[3];
  logic        req_ready[3];
  logic        req_write[3];
  logic [1:0]  req_size[3];
  logic        req_unsigned[3];
  logic [31:0] req_addr[3];
  logic [31:0] req_wdata[3];
  logic        rsp_valid[3];
  logic        rsp_err[3];
  logic [31:0] rsp_rdata[3];
  logic        mem_en[3];
  logic [3:0]  mem_we[3];
  logic [31:0] mem_addr[3];
  logic [31:0] mem_wdata[3];
  logic [31:0] mem_rdata = 32'h80FF7F01;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gd
      mem_access_unit #(
        .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 1 : 3)),
        .CNT_W       (4)
      ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid[g]),
        .req_ready    (req_ready[g]),
        .req_write    (req_write[g]),
        .req_size     (req_size[g]),
        .req_unsigned (req_unsigned[g]),
        .req_addr     (req_addr[g]),
        .req_wdata    (req_wdata[g]),
        .rsp_valid    (rsp_valid[g]),
        .rsp_err      (rsp_err[g]),
        .rsp_rdata    (rsp_rdata[g]),
        .mem_en       (mem_en[g]),
        .mem_we       (mem_we[g]),
        .mem_addr     (mem_addr[g]),
        .mem_wdata    (mem_wdata[g]),
        .mem_rdata    (mem_rdata)
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int u, input logic w, input logic [1:0] sz,
                       input logic un, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid[u]    = 1'b1;
    req_write[u]    = w;
    req_size[u]     = sz;
    req_unsigned[u] = un;
    req_addr[u]     = a;
    req_wdata[u]    = d;
  endtask

  // Accept a load, check mem_en for ws+1 cycles, then the response.
  task automatic do_load(input int u, input int ws, input logic [1:0] sz,
                         input logic un, input logic [31:0] a,
                         input logic [31:0] exp, input string tag);
    issue(u, 1'b0, sz, un, a, 32'h0);
    tick();
    req_valid[u] = 1'b0;
    chk({tag, "_we"}, 32'(mem_we[u]), 32'h0);
    chk({tag, "_addr"}, mem_addr[u], {a[31:2], 2'b00});
    for (int i = 0; i <= ws; i++) begin
      chk({tag, "_en"}, 32'(mem_en[u]), 32'h1);
      chk({tag, "_rvlo"}, 32'(rsp_valid[u]), 32'h0);
      tick();
    end
    chk({tag, "_en_off"}, 32'(mem_en[u]), 32'h0);
    chk({tag, "_rv"}, 32'(rsp_valid[u]), 32'h1);
    chk({tag, "_err"}, 32'(rsp_err[u]), 32'h0);
    chk({tag, "_data"}, rsp_rdata[u], exp);
    tick();
    chk({tag, "_ready"}, 32'(req_ready[u]), 32'h1);
  endtask

  // Misaligned or illegal: response one cycle after accept, no access.
  task automatic do_err(input int u, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input string tag);
    issue(u, w, sz, 1'b0, a, 32'h12345678);
    tick();
    req_valid[u] = 1'b0;
    chk({tag, "_rv"}, 32'(rsp_valid[u]), 32'h1);
    chk({tag, "_err"}, 32'(rsp_err[u]), 32'h1);
    chk({tag, "_data"}, rsp_rdata[u], 32'h0);
    chk({tag, "_en"}, 32'(mem_en[u]), 32'h0);
    chk({tag, "_we"}, 32'(mem_we[u]), 32'h0);
    tick();
    chk({tag, "_en2"}, 32'(mem_en[u]), 32'h0);
    chk({tag, "_rv2"}, 32'(rsp_valid[u]), 32'h0);
    chk({tag, "_ready"}, 32'(req_ready[u]), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_valid[i]    = 1'b0;
      req_write[i]    = 1'b0;
      req_size[i]     = 2'b00;
      req_unsigned[i] = 1'b0;
      req_addr[i]     = 32'h0;
      req_wdata[i]    = 32'h0;
    end
    #1;
    chk("rst_en", 32'(mem_en[1]), 32'h0);
    chk("rst_we", 32'(mem_we[1]), 32'h0);
    chk("rst_addr", mem_addr[1], 32'h0);
    chk("rst_wdata", mem_wdata[1], 32'h0);
    chk("rst_rv", 32'(rsp_valid[1]), 32'h0);
    chk("rst_err", 32'(rsp_err[1]), 32'h0);
    chk("rst_rdata", rsp_rdata[1], 32'h0);
    chk("rst_ready", 32'(req_ready[1]), 32'h1);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Store word, WAIT_STATES=1
    issue(1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    tick();
    req_valid[1] = 1'b0;
    chk("sw_en1", 32'(mem_en[1]), 32'h1);
    chk("sw_we1", 32'(mem_we[1]), 32'hF);
    chk("sw_addr", mem_addr[1], 32'h100);
    chk("sw_wdata", mem_wdata[1], 32'hDEADBEEF);
    chk("sw_ready", 32'(req_ready[1]), 32'h0);
    tick();
    chk("sw_en2", 32'(mem_en[1]), 32'h1);
    chk("sw_we2", 32'(mem_we[1]), 32'h0);
    chk("sw_wdata2", mem_wdata[1], 32'hDEADBEEF);
    chk("sw_rv2", 32'(rsp_valid[1]), 32'h0);
    tick();
    chk("sw_en3", 32'(mem_en[1]), 32'h0);
    chk("sw_rv3", 32'(rsp_valid[1]), 32'h1);
    chk("sw_err", 32'(rsp_err[1]), 32'h0);
    chk("sw_rdata", rsp_rdata[1], 32'h0);
    chk("sw_ready3", 32'(req_ready[1]), 32'h0);
    tick();
    chk("sw_rv4", 32'(rsp_valid[1]), 32'h0);
    chk("sw_ready4", 32'(req_ready[1]), 32'h1);

    // Store byte at 0x103
    issue(1, 1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5);
    tick();
    req_valid[1] = 1'b0;
    chk("sb_we", 32'(mem_we[1]), 32'h8);
    chk("sb_wdata", mem_wdata[1], 32'hA5A5A5A5);
    chk("sb_addr", mem_addr[1], 32'h100);
    tick();
    tick();
    chk("sb_rv", 32'(rsp_valid[1]), 32'h1);
    tick();

    // Store half at 0x102
    issue(1, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234BEEF);
    tick();
    req_valid[1] = 1'b0;
    chk("sh_we", 32'(mem_we[1]), 32'hC);
    chk("sh_wdata", mem_wdata[1], 32'hBEEFBEEF);
    tick();
    tick();
    chk("sh_rv", 32'(rsp_valid[1]), 32'h1);
    tick();

    // Loads from 0x80FF7F01
    do_load(1, 1, 2'b00, 1'b0, 32'h3, 32'hFFFFFF80, "lb3s");
    do_load(1, 1, 2'b00, 1'b1, 32'h3, 32'h00000080, "lb3u");
    do_load(1, 1, 2'b01, 1'b0, 32'h2, 32'hFFFF80FF, "lh2s");
    do_load(1, 1, 2'b01, 1'b1, 32'h0, 32'h00007F01, "lh0u");
    do_load(1, 1, 2'b00, 1'b0, 32'h1, 32'h0000007F, "lb1s");
    do_load(1, 1, 2'b10, 1'b0, 32'h200, 32'h80FF7F01, "lw");

    // Misaligned and illegal requests
    do_err(1, 1'b0, 2'b01, 32'h101, "e_half");
    do_err(1, 1'b0, 2'b11, 32'h100, "e_ill");
    do_err(1, 1'b1, 2'b10, 32'h102, "e_word");

    // Back-to-back, WAIT_STATES=0, valid held high
    issue(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    tick();
    chk("bb_ready0", 32'(req_ready[0]), 32'h0);
    chk("bb_en0", 32'(mem_en[0]), 32'h1);
    chk("bb_addr0", mem_addr[0], 32'h40);
    req_size[0]     = 2'b00;
    req_unsigned[0] = 1'b1;
    req_addr[0]     = 32'h81;
    tick();
    chk("bb_ready1", 32'(req_ready[0]), 32'h0);
    chk("bb_en1", 32'(mem_en[0]), 32'h0);
    chk("bb_rv1", 32'(rsp_valid[0]), 32'h1);
    chk("bb_data1", rsp_rdata[0], 32'h80FF7F01);
    tick();
    chk("bb_ready2", 32'(req_ready[0]), 32'h1);
    chk("bb_en2", 32'(mem_en[0]), 32'h0);
    chk("bb_rv2", 32'(rsp_valid[0]), 32'h0);
    tick();
    req_valid[0] = 1'b0;
    chk("bb_en3", 32'(mem_en[0]), 32'h1);
    chk("bb_ready3", 32'(req_ready[0]), 32'h0);
    chk("bb_addr3", mem_addr[0], 32'h80);
    tick();
    chk("bb_rv4", 32'(rsp_valid[0]), 32'h1);
    chk("bb_data4", rsp_rdata[0], 32'h0000007F);
    tick();

    // Reset mid-access, WAIT_STATES=3
    issue(2, 1'b1, 2'b10, 1'b0, 32'h300, 32'h11223344);
    tick();
    req_valid[2] = 1'b0;
    chk("ra_en", 32'(mem_en[2]), 32'h1);
    chk("ra_we", 32'(mem_we[2]), 32'hF);
    #2;
    reset = 1'b0;
    #1;
    chk("ra_en_async", 32'(mem_en[2]), 32'h0);
    chk("ra_we_async", 32'(mem_we[2]), 32'h0);
    chk("ra_ready", 32'(req_ready[2]), 32'h1);
    tick();
    chk("ra_rv_a", 32'(rsp_valid[2]), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ra_rv_b", 32'(rsp_valid[2]), 32'h0);
      chk("ra_en_b", 32'(mem_en[2]), 32'h0);
    end
    chk("ra_ready2", 32'(req_ready[2]), 32'h1);
    do_load(2, 3, 2'b10, 1'b0, 32'h304, 32'h80FF7F01, "ra_lw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store access unit between the multicycle core's memory port and the data memory.
- Accepts one request at a time over a valid/ready handshake and checks alignment.
- Drives word-aligned memory accesses with per-byte write enables.
- Holds the access for a configurable number of wait states, then returns load data that is extracted and sign- or zero-extended.

Parameters:
WAIT_STATES, 1, extra cycles mem_en is held beyond the first access cycle (0..15)
CNT_W, 4, width of the wait-state counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  core request present
req_ready  output  1  unit can accept a request
req_write  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle completion pulse
rsp_err  output  1  misaligned or illegal-size request, qualified by rsp_valid
rsp_rdata  output  32  extended load data; 0 for stores and errors
mem_en  output  1  memory access strobe
mem_we  output  4  byte write enables
mem_addr  output  32  word address, {req_addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  memory read word, combinational, valid while mem_en=1

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - req_ready=1, because it is decoded from state==IDLE.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1. A request is accepted on a cycle where req_valid=1.
  - On acceptance, latch write, size, unsigned, addr[1:0] and wdata.
  - Error if size=11, if size=01 with addr[0]=1, or if size=10 with addr[1:0]!=0.
  - Error: go to RESP with rsp_err=1; no memory access is made.
  - Otherwise: go to ACCESS and load counter=WAIT_STATES.
- ACCESS:
  - mem_en=1 and mem_addr/mem_wdata are held stable for exactly WAIT_STATES+1 cycles.
  - mem_we is nonzero only in the first ACCESS cycle, so each store writes once.
  - The counter decrements each cycle.
  - When counter==0, sample mem_rdata into the response register and go to RESP.
- RESP:
  - rsp_valid=1 for one cycle; mem_en=0.
  - The next state is IDLE, and req_ready returns to 1 there.
- Timing:
  - Latency from the accept edge is WAIT_STATES+2 cycles to rsp_valid.
  - An error responds 1 cycle after accept.
  - Back-to-back throughput is one request per WAIT_STATES+3 cycles.
- Store lanes:
  - byte: mem_we=4'b0001<<addr[1:0]; wdata byte replicated x4.
  - half: mem_we=4'b0011<<{addr[1],1'b0}; wdata halfword replicated x2.
  - word: mem_we=4'b1111.
- Load extract:
  - sh = rdata >> (8*addr[1:0]).
  - byte: the low 8 bits of sh, extended per req_unsigned.
  - half: the low 16 bits of sh, extended per req_unsigned.
  - word: passed through unchanged.
- rsp_valid has no backpressure; the core must consume the response in that cycle.
- req_valid and the request fields are ignored outside IDLE. A request held across a busy period is accepted only at the next IDLE cycle.
- All outputs except req_ready are registered.
- Reset asserted mid-access:
  - The access is aborted immediately: mem_en and mem_we drop asynchronously.
  - No rsp_valid is produced.
  - The unit is in IDLE at the first edge after reset is released.
- WAIT_STATES=0 gives a single ACCESS cycle.

Decomposition:
- Package mem_pkg:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL).
  - state_t enum (IDLE, ACCESS, RESP).
  - Function byte_en(size, addr_lo) returning the 4-bit enable.
  - Function misaligned(size, addr_lo).
- One combinational sub-module, load_align: inputs rdata, size, addr_lo, unsigned; output 32-bit extended data.
- The FSM, counter and store-lane logic stay in mem_access_unit.

Test Plan:
- Store word:
  - Stimulus: WAIT_STATES=1, addr=0x100, wdata=0xDEADBEEF.
  - Response: mem_we=1111 in the first ACCESS cycle only, mem_en high 2 cycles, rsp_valid 3 cycles after accept, rsp_err=0.
- Store byte:
  - Stimulus: addr=0x103, wdata=0x000000A5.
  - Response: mem_we=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- Loads from mem_rdata=0x80FF7F01:
  - Byte at addr 0x3, signed: rsp_rdata=0xFFFFFF80.
  - Byte at addr 0x3, unsigned: rsp_rdata=0x00000080.
  - Half at addr 0x2, signed: rsp_rdata=0xFFFF80FF.
- Misaligned and illegal requests:
  - Half load at addr 0x101: rsp_valid and rsp_err=1 one cycle after accept, mem_en never asserted, rsp_rdata=0.
  - size=11: same response.
- Back-to-back:
  - Stimulus: req_valid held high for two loads, WAIT_STATES=0.
  - Response: second accept exactly 3 cycles after the first; req_ready=0 during ACCESS and RESP.
- Reset mid-access:
  - Stimulus: reset=0 during ACCESS with WAIT_STATES=3.
  - Response: mem_en drops without waiting for a clock edge, no rsp_valid, req_ready=1, and the next request completes normally.
